// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer. Decides each cycle which pipeline registers load, hold or take
// a bubble. Also runs the HALT drain sequence and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_halt,
    input  logic [2:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_redirect,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_valid,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halt_out,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lu;

    assign lu = ex_load & ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_valid = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        halt_out   = 1'b0;
        state_d    = state_q;
        drain_d    = drain_q;

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_en    = 1'b0;
            idex_valid = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dmem_stall) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end else if (ex_redirect) begin
                        // Squash both younger instructions; a coincident hazard or HALT dies with them
                        ifid_flush = 1'b1;
                        idex_valid = 1'b0;
                    end else if (lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_valid = 1'b0;
                    end else begin
                        if (imem_stall) begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                        if (id_halt) begin
                            state_d = ST_DRAIN;
                            drain_d = DW'(DRAIN_CYCLES);
                        end
                    end
                end
                ST_DRAIN: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_valid = 1'b0;
                    if (dmem_stall) begin
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end else if (drain_q <= DW'(1)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                default: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    idex_valid = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                    halt_out   = 1'b1;
                    state_d    = ST_HALTED;
                end
            endcase
        end
    end

    // Counts every frozen-PC cycle, including drain and halted time, and sticks at all-ones
    assign stall_cnt_d = (!pc_en && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the sequencer.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 5;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       id_rs, id_rt, ex_rd;
    logic             id_rs_used, id_rt_used, id_halt;
    logic             ex_load, ex_redirect, imem_stall, dmem_stall;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_valid;
    logic             exmem_en, memwb_en, halt_out;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 running, 1 draining, 2 halted
    int m_mode   = 0;
    int m_left   = 0;
    int m_stalls = 0;

    logic [9:0] ev, ec;
    wire  [9:0] act_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_valid,
                           exmem_en, memwb_en, halt_out, ctrl_state};

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_halt(id_halt), .ex_rd(ex_rd), .ex_load(ex_load), .ex_redirect(ex_redirect),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_valid(idex_valid), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .halt_out(halt_out), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic model_lu();
        return ex_load && ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    endfunction

    // Expected control bundle plus a care mask for bits the rules leave open
    function automatic void exp_ctl(output logic [9:0] val, output logic [9:0] care);
        logic pc, fe, fl, de, dv, xe, we, h, cfl, cdv;
        logic [1:0] st;
        pc = 0; fe = 0; fl = 0; de = 0; dv = 0; xe = 0; we = 0; h = 0;
        cfl = 1; cdv = 1;
        st = m_mode[1:0];
        if (rst) begin
            fl = 1; st = 2'd0;
        end else if (m_mode == 0) begin
            if (dmem_stall) begin
                dv = 1;
            end else if (ex_redirect) begin
                pc = 1; fe = 1; fl = 1; de = 1; xe = 1; we = 1;
            end else if (model_lu()) begin
                de = 1; xe = 1; we = 1; cfl = 0;
            end else if (imem_stall) begin
                fe = 1; fl = 1; de = 1; dv = 1; xe = 1; we = 1;
            end else begin
                pc = 1; fe = 1; de = 1; dv = 1; xe = 1; we = 1;
            end
        end else if (m_mode == 1) begin
            cfl = 0;
            if (dmem_stall) cdv = 0;
            else begin de = 1; xe = 1; we = 1; end
        end else begin
            h = 1; cfl = 0; cdv = 0;
        end
        val  = {pc, fe, fl, de, dv, xe, we, h, st};
        care = {2'b11, cfl, 1'b1, cdv, 5'b11111};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_stalls = 0;
    endtask

    task automatic model_advance();
        logic [9:0] v, c;
        if (rst) begin
            model_reset();
            return;
        end
        exp_ctl(v, c);
        if (!v[9] && m_stalls < CNT_MAX) m_stalls++;
        if (m_mode == 0) begin
            if (id_halt && !dmem_stall && !ex_redirect && !model_lu()) begin
                m_mode = 1;
                m_left = DRAIN_CYCLES;
            end
        end else if (m_mode == 1 && !dmem_stall) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic rsu,
                         input logic rtu, input logic hlt, input logic [2:0] rd,
                         input logic ld, input logic rdr, input logic ims, input logic dms);
        id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu; id_halt = hlt;
        ex_rd = rd; ex_load = ld; ex_redirect = rdr; imem_stall = ims; dmem_stall = dms;
    endtask

    task automatic quiet();
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_inputs();
        drive(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), 3'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        quiet();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            rand_inputs();
            @(negedge clk);
            checks++;
            if (act_ctl !== 10'b0010000000 || stall_cnt !== '0) begin
                errors++;
                $display("FAIL reset c%0d ctl=%b want=0010000000 cnt=%0d want=0", c, act_ctl, stall_cnt);
            end
            tick();
        end
        quiet();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive(3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            else quiet();
            @(negedge clk);
            exp_ctl(ev, ec);
            checks++;
            if (((act_ctl ^ ev) & ec) !== 10'd0 || stall_cnt !== CNT_W'(m_stalls)) begin
                errors++;
                $display("FAIL load_use c%0d ctl=%b want=%b cnt=%0d want=%0d",
                         c, act_ctl, ev, stall_cnt, m_stalls);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== CNT_W'(1) || pc_en !== 1'b1 || idex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_use_after cnt=%0d pc_en=%b idex_valid=%b want 1 1 1",
                     stall_cnt, pc_en, idex_valid);
        end
        tick();
    endtask

    task automatic test_unused_regs();
        do_reset();
        drive(3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        exp_ctl(ev, ec);
        checks++;
        if (((act_ctl ^ ev) & ec) !== 10'd0 || pc_en !== 1'b1 || idex_valid !== 1'b1) begin
            errors++;
            $display("FAIL unused_regs ctl=%b want=%b", act_ctl, ev);
        end
        tick();
    endtask

    task automatic test_redirect_priority();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive(3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
            else quiet();
            @(negedge clk);
            exp_ctl(ev, ec);
            checks++;
            if (((act_ctl ^ ev) & ec) !== 10'd0 || ctrl_state !== 2'd0) begin
                errors++;
                $display("FAIL redirect c%0d ctl=%b want=%b state=%0d want=0",
                         c, act_ctl, ev, ctrl_state);
            end
            tick();
        end
    endtask

    task automatic test_dmem_stall();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
            else quiet();
            @(negedge clk);
            exp_ctl(ev, ec);
            checks++;
            if (((act_ctl ^ ev) & ec) !== 10'd0 || stall_cnt !== CNT_W'(m_stalls)) begin
                errors++;
                $display("FAIL dmem_stall c%0d ctl=%b want=%b cnt=%0d want=%0d",
                         c, act_ctl, ev, stall_cnt, m_stalls);
            end
            if (c == 4) begin
                checks++;
                if (stall_cnt !== CNT_W'(4) || act_ctl[9] !== 1'b1) begin
                    errors++;
                    $display("FAIL dmem_resume cnt=%0d want=4 pc_en=%b want=1", stall_cnt, pc_en);
                end
            end
            tick();
        end
    endtask

    task automatic test_halt_drain();
        int first_h;
        first_h = -1;
        do_reset();
        for (int k = 0; k < 41; k++) begin
            if (k == 0) drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (k <= 5) drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0,
                                   (k == 4), (k == 1), (k == 2 || k == 3));
            else rand_inputs();
            @(negedge clk);
            exp_ctl(ev, ec);
            checks++;
            if (((act_ctl ^ ev) & ec) !== 10'd0 || stall_cnt !== CNT_W'(m_stalls)) begin
                errors++;
                $display("FAIL halt_drain k%0d ctl=%b want=%b cnt=%0d want=%0d",
                         k, act_ctl, ev, stall_cnt, m_stalls);
            end
            if (halt_out === 1'b1 && first_h < 0) first_h = k;
            tick();
        end
        checks++;
        if (first_h != 6) begin
            errors++;
            $display("FAIL halt_timing first halt_out cycle=%0d want=6", first_h);
        end
        checks++;
        if (stall_cnt !== CNT_W'(CNT_MAX)) begin
            errors++;
            $display("FAIL stall_saturate cnt=%0d want=%0d", stall_cnt, CNT_MAX);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else quiet();
            @(negedge clk);
            exp_ctl(ev, ec);
            checks++;
            if (((act_ctl ^ ev) & ec) !== 10'd0) begin
                errors++;
                $display("FAIL async_pre c%0d ctl=%b want=%b", c, act_ctl, ev);
            end
            tick();
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (act_ctl !== 10'b0010000000 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL async_assert ctl=%b want=0010000000 cnt=%0d want=0", act_ctl, stall_cnt);
        end
        tick();
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (act_ctl !== 10'b1101111000 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL async_release ctl=%b want=1101111000 cnt=%0d want=0", act_ctl, stall_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            rand_inputs();
            @(negedge clk);
            exp_ctl(ev, ec);
            checks++;
            if (((act_ctl ^ ev) & ec) !== 10'd0 || stall_cnt !== CNT_W'(m_stalls)) begin
                errors++;
                $display("FAIL random c%0d ctl=%b want=%b care=%b cnt=%0d want=%0d",
                         c, act_ctl, ev, ec, stall_cnt, m_stalls);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        quiet();
        test_reset();
        test_load_use();
        test_unused_regs();
        test_redirect_priority();
        test_dmem_stall();
        test_halt_drain();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
